// File: rtl/karatsuba_seq_ctrl.sv
// Sequential Karatsuba multiplier: one shared (H+1)x(H+1) multiplier is reused
// over three product steps, and the partial products are then combined into the full product.
module karatsuba_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [WIDTH-1:0]   req_b,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] res_data,
    output logic               busy
);
    localparam int H  = WIDTH / 2;
    localparam int PW = 2 * H + 2;
    localparam int RW = 2 * WIDTH;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S_HI  = 3'd1,
        S_LO  = 3'd2,
        S_MID = 3'd3,
        S_CMB = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [2*H-1:0]   p1_r;
    logic [2*H-1:0]   p2_r;
    logic [PW-1:0]    pm_r;

    logic [H:0]       mul_x_s;
    logic [H:0]       mul_y_s;
    logic [PW-1:0]    mul_p_s;
    logic [RW-1:0]    p1_ext_s;
    logic [RW-1:0]    p2_ext_s;
    logic [RW-1:0]    pm_ext_s;
    logic [RW-1:0]    mid_s;
    logic [RW-1:0]    comb_s;

    // Operand mux for the single shared multiplier; the half sums keep their carry bit.
    always_comb begin
        mul_x_s = {(H+1){1'b0}};
        mul_y_s = {(H+1){1'b0}};
        case (state_r)
            S_HI: begin
                mul_x_s = {1'b0, a_r[WIDTH-1:H]};
                mul_y_s = {1'b0, b_r[WIDTH-1:H]};
            end
            S_LO: begin
                mul_x_s = {1'b0, a_r[H-1:0]};
                mul_y_s = {1'b0, b_r[H-1:0]};
            end
            S_MID: begin
                mul_x_s = {1'b0, a_r[WIDTH-1:H]} + {1'b0, a_r[H-1:0]};
                mul_y_s = {1'b0, b_r[WIDTH-1:H]} + {1'b0, b_r[H-1:0]};
            end
            default: begin
                mul_x_s = {(H+1){1'b0}};
                mul_y_s = {(H+1){1'b0}};
            end
        endcase
    end

    assign mul_p_s = PW'(mul_x_s) * PW'(mul_y_s);

    // Recombination in full result width; the middle term can never go negative.
    always_comb begin
        p1_ext_s = RW'(p1_r);
        p2_ext_s = RW'(p2_r);
        pm_ext_s = RW'(pm_r);
        mid_s    = pm_ext_s - p1_ext_s - p2_ext_s;
        comb_s   = (p1_ext_s << WIDTH) + (mid_s << H) + p2_ext_s;
    end

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            p1_r      <= {(2*H){1'b0}};
            p2_r      <= {(2*H){1'b0}};
            pm_r      <= {PW{1'b0}};
            res_data  <= {RW{1'b0}};
            res_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        a_r       <= req_a;
                        b_r       <= req_b;
                        state_r   <= S_HI;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_HI: begin
                    p1_r    <= mul_p_s[2*H-1:0];
                    state_r <= S_LO;
                end
                S_LO: begin
                    p2_r    <= mul_p_s[2*H-1:0];
                    state_r <= S_MID;
                end
                S_MID: begin
                    pm_r    <= mul_p_s;
                    state_r <= S_CMB;
                end
                S_CMB: begin
                    res_data  <= comb_s;
                    res_valid <= 1'b1;
                    state_r   <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    res_valid <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_karatsuba_seq_ctrl.sv
// Self-checking bench for karatsuba_seq_ctrl; expected products come from plain multiplication.
module tb_karatsuba_seq_ctrl;
    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        busy;

    int errors = 0;
    int checks = 0;

    karatsuba_seq_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        return {16'd0, a} * {16'd0, b};
    endfunction

    // Present one request while idle, then count cycles until res_valid (-1 on timeout).
    task automatic issue(input logic [15:0] a, input logic [15:0] b, output int lat);
        req_a = a;
        req_b = b;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            if (res_valid) begin
                lat = k - 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat < 0 && res_valid) lat = 20;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        res_ready = 1'b1;
        req_a = 16'd0;
        req_b = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (res_valid !== 1'b0 || res_data !== 32'd0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: valid=%b data=%h busy=%b ready=%b, want 0 0 0 1",
                     res_valid, res_data, busy, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b busy=%b, want 1 0", req_ready, busy);
        end
    endtask

    task automatic test_basic();
        int lat;
        res_ready = 1'b1;
        issue(16'h1234, 16'h5678, lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL basic_latency: got %0d want 4", lat);
        end
        checks++;
        if (res_data !== 32'h06260060) begin
            errors++;
            $display("FAIL basic_data: got %h want 06260060", res_data);
        end
        @(posedge clk); #1;
        checks++;
        if (res_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse: valid=%b ready=%b busy=%b want 0 1 0",
                     res_valid, req_ready, busy);
        end
    endtask

    task automatic test_corners();
        logic [15:0] av [5] = '{16'hFFFF, 16'h00FF, 16'h0000, 16'h0001, 16'hFF00};
        logic [15:0] bv [5] = '{16'hFFFF, 16'hFF00, 16'hABCD, 16'hABCD, 16'hFFFF};
        logic [31:0] ev [5] = '{32'hFFFE0001, 32'h00FE0100, 32'h00000000, 32'h0000ABCD, 32'hFEFF0100};
        int lat;
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            issue(av[i], bv[i], lat);
            checks++;
            if (lat !== 4 || res_data !== ev[i]) begin
                errors++;
                $display("FAIL corner%0d: %h*%h got %h lat %0d want %h lat 4",
                         i, av[i], bv[i], res_data, lat, ev[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [15:0] b;
        int lat;
        res_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            a = 16'($urandom_range(0, 65535));
            b = 16'($urandom_range(0, 65535));
            if (i % 5 == 0) a = a | 16'h8080;
            issue(a, b, lat);
            checks++;
            if (lat !== 4 || res_data !== ref_mul(a, b)) begin
                errors++;
                $display("FAIL random%0d: %h*%h got %h lat %0d want %h lat 4",
                         i, a, b, res_data, lat, ref_mul(a, b));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [31:0] exp_v;
        exp_v = ref_mul(16'hBEEF, 16'h1357);
        res_ready = 1'b0;
        issue(16'hBEEF, 16'h1357, lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL bp_latency: got %0d want 4", lat);
        end
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                req_a = 16'h0101;
                req_b = 16'h0202;
                req_valid = 1'b1;
            end else begin
                req_valid = 1'b0;
            end
            @(posedge clk); #1;
            checks++;
            if (res_valid !== 1'b1 || res_data !== exp_v || req_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b data=%h ready=%b busy=%b want 1 %h 0 1",
                         c, res_valid, res_data, req_ready, busy, exp_v);
            end
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (res_valid !== 1'b0 || req_ready !== 1'b1 || res_data !== exp_v) begin
            errors++;
            $display("FAIL bp_release: valid=%b ready=%b data=%h want 0 1 %h",
                     res_valid, req_ready, res_data, exp_v);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_accept: busy=%b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] av [3] = '{16'h1111, 16'hF00D, 16'h7FFF};
        logic [15:0] bv [3] = '{16'h2222, 16'hCAFE, 16'h8001};
        int acc [3];
        int acc_n = 0;
        int res_n = 0;
        int cyc = 0;
        logic prev_busy;
        res_ready = 1'b1;
        prev_busy = busy;
        req_a = av[0];
        req_b = bv[0];
        req_valid = 1'b1;
        while (cyc < 60 && res_n < 3) begin
            @(posedge clk); #1;
            cyc++;
            if (busy && !prev_busy && acc_n < 3) begin
                acc[acc_n] = cyc;
                acc_n++;
                if (acc_n < 3) begin
                    req_a = av[acc_n];
                    req_b = bv[acc_n];
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (res_valid && res_n < 3) begin
                checks++;
                if (res_data !== ref_mul(av[res_n], bv[res_n])) begin
                    errors++;
                    $display("FAIL b2b_data%0d: got %h want %h",
                             res_n, res_data, ref_mul(av[res_n], bv[res_n]));
                end
                res_n++;
            end
            prev_busy = busy;
        end
        req_valid = 1'b0;
        checks++;
        if (acc_n !== 3 || res_n !== 3) begin
            errors++;
            $display("FAIL b2b_count: acc=%0d res=%0d want 3 3", acc_n, res_n);
        end else begin
            checks++;
            if (acc[1] - acc[0] !== 6 || acc[2] - acc[1] !== 6) begin
                errors++;
                $display("FAIL b2b_interval: got %0d %0d want 6 6",
                         acc[1] - acc[0], acc[2] - acc[1]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midop();
        int lat;
        res_ready = 1'b1;
        req_a = 16'hAAAA;
        req_b = 16'h5555;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midop_busy: busy=%b want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || res_data !== 32'd0) begin
            errors++;
            $display("FAIL midop_reset: valid=%b busy=%b ready=%b data=%h want 0 0 1 0",
                     res_valid, busy, req_ready, res_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            checks++;
            if (res_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midop_quiet%0d: valid=%b busy=%b want 0 0", c, res_valid, busy);
            end
        end
        issue(16'h0003, 16'h0005, lat);
        checks++;
        if (lat !== 4 || res_data !== 32'h0000000F) begin
            errors++;
            $display("FAIL midop_next: got %h lat %0d want 0000000f lat 4", res_data, lat);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
